// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate data cache.
// Sits between the CPU data port and a valid/ready main-memory port.
// Read hits return data in the cycle after the capture edge. Read misses
// and all stores hold the CPU with stall until memory has served them.
//
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   cpu_addr/re/we/din  : CPU request (byte address, read, byte enables, data)
//   cpu_dout, stall     : read data (valid when stall=0) and pipeline hold
//   mem_req_*           : memory request (valid/ready, rnw, addr, data, mask)
//   mem_resp_valid/data : memory read response, one per read request
module dcache_wt #(
  parameter int unsigned LINES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_re,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_rnw,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_mask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int unsigned INDEX = $clog2(LINES);
  localparam int unsigned TAG   = 30 - INDEX;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Captured CPU request; word address only, byte offset is irrelevant.
  logic        req_v_q,    req_v_d;
  logic [29:0] req_addr_q, req_addr_d;
  logic [3:0]  req_we_q,   req_we_d;
  logic [31:0] req_din_q,  req_din_d;

  // Line storage with combinational read.
  logic [LINES-1:0] valid_q;
  logic [TAG-1:0]   tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [INDEX-1:0] idx;
  logic [TAG-1:0]   req_tag;
  logic             is_store;
  logic             hit;
  logic             fill_en;
  logic             merge_en;
  logic             clr_req;

  // Byte offset of the CPU address never reaches the cache or memory.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cpu_addr[1:0];

  assign idx      = req_addr_q[INDEX-1:0];
  assign req_tag  = req_addr_q[29:INDEX];
  assign is_store = |req_we_q;
  assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);

  // Memory request payload comes straight from the held request, so it is
  // stable for as long as the handshake is pending.
  assign mem_req_addr = {req_addr_q, 2'b00};
  assign mem_req_data = req_din_q;
  assign mem_req_mask = req_we_q;

  // Controller: next state, CPU-side outputs, memory strobes, array enables.
  always_comb begin
    state_d       = state_q;
    stall         = 1'b0;
    cpu_dout      = 32'h0;
    mem_req_valid = 1'b0;
    mem_req_rnw   = 1'b1;
    fill_en       = 1'b0;
    merge_en      = 1'b0;
    clr_req       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_v_q) begin
          if (is_store) begin
            stall    = 1'b1;
            merge_en = hit;
            state_d  = WR_REQ;
          end else if (hit) begin
            cpu_dout = data_q[idx];
          end else begin
            stall   = 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_rnw   = 1'b1;
        stall         = 1'b1;
        // A response arriving alongside ready is not ours yet; only ready counts.
        if (mem_req_ready) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        stall = 1'b1;
        // Request is still held, so the return to IDLE re-looks up and hits.
        if (mem_resp_valid) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      WR_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_rnw   = 1'b0;
        stall         = 1'b1;
        // Retire the store so the following IDLE cycle drops stall.
        if (mem_req_ready) begin
          clr_req = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request capture: load on every unstalled edge, hold while stalled.
  always_comb begin
    req_v_d    = req_v_q;
    req_addr_d = req_addr_q;
    req_we_d   = req_we_q;
    req_din_d  = req_din_q;
    if (!stall) begin
      req_v_d    = cpu_re | (|cpu_we);
      req_addr_d = cpu_addr[31:2];
      req_we_d   = cpu_we;
      req_din_d  = cpu_din;
    end else if (clr_req) begin
      req_v_d = 1'b0;
    end
  end

  // State, request and valid-bit registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      req_v_q    <= 1'b0;
      req_addr_q <= 30'h0;
      req_we_q   <= 4'h0;
      req_din_q  <= 32'h0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_v_q    <= req_v_d;
      req_addr_q <= req_addr_d;
      req_we_q   <= req_we_d;
      req_din_q  <= req_din_d;
      if (fill_en) begin
        valid_q[idx] <= 1'b1;
      end
    end
  end

  // Tag/data arrays: fill on read response, byte merge on store hit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill_en) begin
        tag_q[idx]  <= req_tag;
        data_q[idx] <= mem_resp_data;
      end else if (merge_en) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (req_we_q[b]) begin
            data_q[idx][8*b +: 8] <= req_din_q[8*b +: 8];
          end
        end
      end
    end
  end

endmodule
